booth_issue_ctrl: RTL
=====================

# booth_issue_ctrl

Upstream issue/collect sequencer for the 8-bit Booth multiplier (data_path + controller pair). It accepts operand pairs over a valid/ready handshake and replays them onto the multiplier's serial load protocol: a one-cycle `start`, then the multiplicand, then the multiplier on the shared `data_in` bus. It waits for `done`, captures the 16-bit `{A,Q}` product, and presents it downstream over a second valid/ready handshake. A watchdog flags a multiplier that never completes.

## Interface
- `W`, 8: operand width; the product is 2W bits.
- `TIMEOUT`, 24: maximum WAIT cycles allowed for `mul_done`; legal range 1..255.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_a`  in  W  multiplicand, two's complement.
- `in_b`  in  W  multiplier, two's complement.
- `mul_start`  out  1  to multiplier `start`.
- `mul_data`  out  W  to multiplier `data_in`.
- `mul_done`  in  1  from multiplier `done`.
- `mul_result`  in  2W  multiplier `{A,Q}`.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  downstream accepts the product.
- `out_product`  out  2W  signed product.
- `out_err`  out  1  qualifies `out_valid`: timeout; product forced to 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, LDM, LDQ, WAIT, DRAIN. All outputs are registered, except `in_ready = (state==IDLE) && rst_n`.
- IDLE: when `in_valid && in_ready`, latch `in_a` and `in_b` into operand registers and go to START.
- START: `mul_start=1` and `mul_data=0`; go to LDM. `mul_start` is high for exactly one cycle per operation.
- LDM: `mul_data=op_a`; go to LDQ.
- LDQ: `mul_data=op_b`; load the watchdog with TIMEOUT; go to WAIT.
- WAIT: `mul_data=0`.
  - If `mul_done=1`: capture `mul_result` into `out_product`, set `out_valid=1` and `out_err=0`, go to DRAIN.
  - Otherwise decrement the watchdog. When it would go from 1 to 0, set `out_valid=1`, `out_err=1`, `out_product=0`, go to DRAIN.
  - If `mul_done` arrives on the same cycle as expiry, `mul_done` wins.
- DRAIN: hold `out_valid`, `out_product` and `out_err` stable until `out_ready=1`. On that edge clear `out_valid` and `out_err` and go to IDLE. `out_product` keeps its last value.
- `mul_done` is ignored in every state other than WAIT.
- `mul_result` is sampled only on the capture edge; the sequencer does not interpret it.
- Product arithmetic is signed 2W-bit. The sequencer passes the multiplier output through unmodified.
- Reset mid-operation:
  - Any state returns to IDLE on the first edge with `rst_n=0`.
  - Any in-flight product is discarded and no `out_valid` is emitted for it.
  - The multiplier must be reset alongside; a late `mul_done` lands in IDLE and is ignored.

## Timing
- Reset values: `mul_start=0`, `mul_data=0`, `out_valid=0`, `out_err=0`, `out_product=0`, `busy=0`, watchdog=0, state=IDLE. `in_ready` is 0 while `rst_n=0` and 1 on the first cycle after release.
- Acceptance at edge E0:
  - `mul_start=1` during cycle E0..E1.
  - `mul_data=a` during E1..E2.
  - `mul_data=b` during E2..E3.
  - WAIT from E3.
- The multiplier samples `start` at E1, `a` at E2 and `b` at E3.
- `out_valid` rises on the edge that samples `mul_done=1` in WAIT.
- Zero-stall latency from acceptance to `out_valid` = 3 + D cycles, where D is the number of WAIT cycles until `mul_done`.
- Timeout: `out_valid` with `out_err` rises exactly TIMEOUT edges after entering WAIT.
- Throughput: one operation in flight. `in_ready` re-asserts the cycle after the `out_valid && out_ready` edge.
- Back-to-back: a new pair can be accepted on the edge immediately following the drain handshake.

## Test plan
- a=0x06, b=0x04, stub returns 0x0018 after 10 cycles → `mul_start` high exactly 1 cycle; `mul_data` sequence 0x00, 0x06, 0x04; `out_product=0x0018`, `out_err=0`, latency 13.
- With the real multiplier: a=0xFD (−3), b=0x05 → `out_product=0xFFF1`. a=0x80, b=0x80 → `0x4000`.
- Stub never asserts `mul_done`, TIMEOUT=24 → `out_valid=1`, `out_err=1`, `out_product=0` exactly 24 edges after entering WAIT; one `out_ready` pulse returns to IDLE.
- `out_ready` held low 5 cycles after `out_valid` → product stable, `in_ready=0` and `in_valid` ignored; accept occurs the cycle after `out_ready` rises.
- `rst_n` low for 1 cycle in WAIT, then `mul_done` pulse → no `out_valid`; all outputs at reset values; next pair 2×3 yields 0x0006.
- Three back-to-back pairs with `out_ready` tied 1 → products in order. `mul_done` injected during LDM is ignored. `mul_done` on the expiry cycle gives `out_err=0`.

Source files
------------

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl: issue/collect sequencer in front of the serial-load Booth
// multiplier. Accepts an operand pair over valid/ready, replays it as
// start -> multiplicand -> multiplier on the shared data bus, waits for done
// (bounded by a watchdog) and returns the 2W-bit product over valid/ready.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready combinational: IDLE && rst_n)
//   in_a, in_b         multiplicand / multiplier, two's complement
//   mul_start          one-cycle start pulse to the multiplier
//   mul_data           serial operand bus to the multiplier
//   mul_done           multiplier completion
//   mul_result         multiplier {A,Q}
//   out_valid/out_ready product handshake
//   out_product        captured product (0 on timeout)
//   out_err            qualifies out_valid: watchdog expired
//   busy               high in every state except IDLE
module booth_issue_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_start,
  output logic [W-1:0]   mul_data,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_err,
  output logic           busy
);

  localparam int unsigned PW  = 2 * W;
  localparam int unsigned WDW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LDM,
    S_LDQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           mul_start_d;
  logic [W-1:0]   mul_data_d;
  logic           out_valid_d;
  logic           out_err_d;
  logic [PW-1:0]  out_product_d;
  logic           busy_d;

  // Only combinational output; gated by rst_n so nothing is accepted in reset.
  assign in_ready = (state_q == S_IDLE) && rst_n;

  // State, operand, watchdog and registered-output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      wdog_q      <= '0;
      mul_start   <= 1'b0;
      mul_data    <= '0;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      out_product <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      wdog_q      <= wdog_d;
      mul_start   <= mul_start_d;
      mul_data    <= mul_data_d;
      out_valid   <= out_valid_d;
      out_err     <= out_err_d;
      out_product <= out_product_d;
      busy        <= busy_d;
    end
  end

  // Next state plus the values the output registers take on the coming edge,
  // so each bus phase appears in the cycle that follows its transition.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    wdog_d        = wdog_q;
    mul_start_d   = 1'b0;
    mul_data_d    = '0;
    out_valid_d   = out_valid;
    out_err_d     = out_err;
    out_product_d = out_product;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_a_d      = in_a;
          op_b_d      = in_b;
          mul_start_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        mul_data_d = op_a_q;
        state_d    = S_LDM;
      end
      S_LDM: begin
        mul_data_d = op_b_q;
        state_d    = S_LDQ;
      end
      S_LDQ: begin
        wdog_d  = WDW'(TIMEOUT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a simultaneous watchdog expiry
        if (mul_done) begin
          out_product_d = mul_result;
          out_valid_d   = 1'b1;
          out_err_d     = 1'b0;
          state_d       = S_DRAIN;
        end else if (wdog_q == WDW'(1)) begin
          wdog_d        = '0;
          out_product_d = '0;
          out_valid_d   = 1'b1;
          out_err_d     = 1'b1;
          state_d       = S_DRAIN;
        end else begin
          wdog_d = wdog_q - WDW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
